// File: rtl/pm_sleep_wake_ctrl.sv
// Always-on initiator for the PMU sleep / power-down handshake with masked wake and exit sequencing.
// Optional auto-wake down-counter is built only when WAKE_TIMER_EN is defined.
module pm_sleep_wake_ctrl #(
  parameter int NUM_WAKE      = 4,
  parameter int TIMER_W       = 16,
  parameter int ACK_TIMEOUT   = 64,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_sleep,
  input  logic                req_power_down,
  input  logic [NUM_WAKE-1:0] wake_src,
  input  logic [NUM_WAKE-1:0] wake_mask,
  input  logic [TIMER_W-1:0]  wake_timer_load,
  input  logic                pm_sleep_active,
  input  logic                pm_power_down_active,
  input  logic                err_clear,
  output logic                sleep_mode,
  output logic                power_down,
  output logic                cpu_hold,
  output logic                wake_pulse,
  output logic [NUM_WAKE:0]   wake_cause,
  output logic                err_timeout,
  output logic                busy
);

  localparam int CNT_MAX = (ACK_TIMEOUT > SETTLE_CYCLES) ? ACK_TIMEOUT : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    RUN, SLP_REQ, SLEEP, PD_REQ, PDOWN, EXIT, SETTLE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_wake;
  logic               w_timerHit;
  logic               w_ackTo;
  logic               w_settleDone;
  logic               w_setErr;

  logic               w_sleepNext;
  logic               w_pdNext;
  logic               w_holdNext;
  logic               w_pulseNext;
  logic               w_causeLoad;
  logic [NUM_WAKE:0]  w_causeNext;
  logic               w_errNext;

  logic               r_sleepMode;
  logic               r_powerDown;
  logic               r_hold;
  logic               r_pulse;
  logic [NUM_WAKE:0]  r_cause;
  logic               r_err;

  assign w_wake       = |(wake_src & wake_mask);
  assign w_ackTo      = (r_cnt >= CNT_W'(ACK_TIMEOUT - 1));
  assign w_settleDone = (r_cnt >= CNT_W'(SETTLE_CYCLES - 1));

`ifdef WAKE_TIMER_EN
  logic [TIMER_W-1:0] r_timer;

  // Loaded on the REQ->asleep edge; a load of zero never reaches the hit value of one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_timer <= '0;
    else if ((r_state == SLP_REQ && w_next == SLEEP) || (r_state == PD_REQ && w_next == PDOWN))
      r_timer <= wake_timer_load;
    else if ((r_state == SLEEP || r_state == PDOWN) && r_timer != '0)
      r_timer <= r_timer - 1'b1;
  end

  assign w_timerHit = (r_state == SLEEP || r_state == PDOWN) && (r_timer == TIMER_W'(1));
`else
  logic w_unusedTimerLoad;
  assign w_unusedTimerLoad = ^wake_timer_load;
  assign w_timerHit        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // A wake seen while still requesting wins over a coincident ack; a released ack wins over timeout.
  always_comb begin
    w_next   = r_state;
    w_setErr = 1'b0;
    case (r_state)
      RUN: begin
        if (req_power_down)  w_next = PD_REQ;
        else if (req_sleep)  w_next = SLP_REQ;
      end
      SLP_REQ: begin
        if (w_wake)               w_next = EXIT;
        else if (pm_sleep_active) w_next = SLEEP;
        else if (w_ackTo) begin
          w_next   = EXIT;
          w_setErr = 1'b1;
        end
      end
      PD_REQ: begin
        if (w_wake)                    w_next = EXIT;
        else if (pm_power_down_active) w_next = PDOWN;
        else if (w_ackTo) begin
          w_next   = EXIT;
          w_setErr = 1'b1;
        end
      end
      SLEEP, PDOWN: begin
        if (w_wake || w_timerHit) w_next = EXIT;
      end
      EXIT: begin
        if (!pm_sleep_active && !pm_power_down_active) w_next = SETTLE;
        else if (w_ackTo) begin
          w_next   = SETTLE;
          w_setErr = 1'b1;
        end
      end
      SETTLE: begin
        if (w_settleDone) w_next = RUN;
      end
      default: w_next = RUN;
    endcase
  end

  always_comb begin
    w_sleepNext = (w_next == SLP_REQ) || (w_next == SLEEP);
    w_pdNext    = (w_next == PD_REQ)  || (w_next == PDOWN);
    w_holdNext  = (w_next != RUN);
    w_pulseNext = (r_state == SETTLE) && (w_next == RUN);
    w_causeLoad = (w_next == EXIT) && (r_state != EXIT);
    w_causeNext = {w_timerHit, wake_src & wake_mask};
    w_errNext   = w_setErr | (r_err & ~err_clear);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sleepMode <= 1'b0;
      r_powerDown <= 1'b0;
      r_hold      <= 1'b0;
      r_pulse     <= 1'b0;
      r_cause     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_sleepMode <= w_sleepNext;
      r_powerDown <= w_pdNext;
      r_hold      <= w_holdNext;
      r_pulse     <= w_pulseNext;
      r_err       <= w_errNext;
      if (w_causeLoad)
        r_cause <= w_causeNext;
    end
  end

  assign sleep_mode  = r_sleepMode;
  assign power_down  = r_powerDown;
  assign cpu_hold    = r_hold;
  assign busy        = r_hold;
  assign wake_pulse  = r_pulse;
  assign wake_cause  = r_cause;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_pm_sleep_wake_ctrl.sv
// Bench for pm_sleep_wake_ctrl: each transaction's event edges are predicted arithmetically,
// then every cycle of the transaction is compared against those predictions.
module tb_pm_sleep_wake_ctrl;

  localparam int NW     = 4;
  localparam int TW     = 16;
  localparam int ACK_TO = 64;
  localparam int SETTLE = 8;
  localparam int INF    = 1000000;
`ifdef WAKE_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_sleep, req_power_down;
  logic [NW-1:0] wake_src, wake_mask;
  logic [TW-1:0] wake_timer_load;
  logic          pm_sleep_active, pm_power_down_active, err_clear;
  logic          sleep_mode, power_down, cpu_hold, wake_pulse, err_timeout, busy;
  logic [NW:0]   wake_cause;

  always #5 clk = ~clk;

  pm_sleep_wake_ctrl #(
    .NUM_WAKE(NW), .TIMER_W(TW), .ACK_TIMEOUT(ACK_TO), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst(rst),
    .req_sleep(req_sleep), .req_power_down(req_power_down),
    .wake_src(wake_src), .wake_mask(wake_mask), .wake_timer_load(wake_timer_load),
    .pm_sleep_active(pm_sleep_active), .pm_power_down_active(pm_power_down_active),
    .err_clear(err_clear),
    .sleep_mode(sleep_mode), .power_down(power_down), .cpu_hold(cpu_hold),
    .wake_pulse(wake_pulse), .wake_cause(wake_cause), .err_timeout(err_timeout), .busy(busy)
  );

  int          total = 0;
  int          bad   = 0;
  logic [NW:0] expCause = '0;
  logic        expErr   = 1'b0;

  task automatic checkOutput(input string tag, input int k, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // kind: 0 sleep, 1 power-down, 2 both. Edge k=0 is the request edge; wake is seen from edge w,
  // the PMU acks da samples after seeing the request and releases dr samples after the drop.
  task automatic applyStimulus(input int kind, input int da, input int w,
                               input logic [NW-1:0] wbits, input logic [NW-1:0] mask,
                               input int n, input int dr, input int clrAt,
                               input bit inject, input int kMax);
    int          wEff, nEff, tExit, tSettle, tRun, errEdge, kEnd, hiCnt, loCnt, tTimer, tWake, e;
    int          ackState;
    bit          pd, reqTo, exTo;
    logic [NW:0] newCause;
    logic        errNow, lvl;

    pd     = (kind != 0);
    wEff   = ((wbits & mask) != '0) ? w : INF;
    nEff   = TIMER_ON ? n : 0;
    reqTo  = 1'b0;
    exTo   = 1'b0;
    tTimer = INF;
    if (wEff <= da && wEff <= ACK_TO) begin
      tExit    = wEff;
      newCause = {1'b0, wbits & mask};
    end else if (da <= ACK_TO) begin
      tTimer   = (nEff > 0) ? da + nEff : INF;
      tWake    = (wEff == INF) ? INF : ((wEff > da) ? wEff : da + 1);
      tExit    = (tTimer < tWake) ? tTimer : tWake;
      newCause = '0;
      newCause[NW] = (tExit == tTimer);
      newCause[NW-1:0] = (tExit >= wEff) ? (wbits & mask) : '0;
    end else begin
      tExit    = ACK_TO;
      reqTo    = 1'b1;
      newCause = '0;
    end
    if (tExit >= INF) begin
      tSettle = INF;
      tRun    = INF;
    end else begin
      if (da > tExit)         tSettle = tExit + 1;
      else if (dr > ACK_TO) begin
        tSettle = tExit + ACK_TO;
        exTo    = 1'b1;
      end else                tSettle = tExit + dr;
      tRun = tSettle + SETTLE;
    end
    errEdge = reqTo ? tExit : (exTo ? tSettle : -1);
    kEnd    = (tRun + 1 < kMax) ? tRun + 1 : kMax;

    req_sleep       = (kind != 1);
    req_power_down  = (kind != 0);
    wake_mask       = mask;
    wake_timer_load = TW'(n);
    wake_src        = NW'($urandom) & ~mask;
    err_clear       = 1'b0;
    hiCnt = 0;
    loCnt = 0;
    ackState = 0;
    errNow = expErr;

    for (int k = 0; k <= kEnd; k++) begin
      @(negedge clk);
      if (k == errEdge)     errNow = 1'b1;
      else if (k == clrAt)  errNow = 1'b0;
      checkOutput("sleep_mode", k, sleep_mode, !pd && (k < tExit));
      checkOutput("power_down", k, power_down, pd && (k < tExit));
      checkOutput("cpu_hold", k, cpu_hold, k < tRun);
      checkOutput("busy", k, busy, k < tRun);
      checkOutput("wake_pulse", k, wake_pulse, k == tRun);
      checkOutput("wake_cause", k, wake_cause, (k >= tExit) ? newCause : expCause);
      checkOutput("err_timeout", k, err_timeout, errNow);

      lvl = pd ? power_down : sleep_mode;
      if (ackState == 0) begin
        if (lvl) hiCnt++;
        if (hiCnt == da) ackState = 1;
      end else if (ackState == 1) begin
        if (!lvl) loCnt++;
        if (loCnt == dr) ackState = 2;
      end
      pm_sleep_active      = (ackState == 1) && !pd;
      pm_power_down_active = (ackState == 1) && pd;

      e = k + 1;
      req_sleep      = inject && (e <= tRun) && ($urandom_range(0, 3) == 0);
      req_power_down = inject && (e <= tRun) && ($urandom_range(0, 3) == 0);
      wake_src       = ((e >= w && e <= tExit) ? wbits : '0) | (NW'($urandom) & ~mask);
      err_clear      = (e == clrAt);
    end

    req_sleep            = 1'b0;
    req_power_down       = 1'b0;
    wake_src             = '0;
    err_clear            = 1'b0;
    pm_sleep_active      = 1'b0;
    pm_power_down_active = 1'b0;
    if (kEnd >= tExit) expCause = newCause;
    expErr = errNow;
  endtask

  initial begin
    int kind, da, w, n, dr, clrAt;
    logic [NW-1:0] mask, wbits;
    bit inject;

    rst = 1'b1;
    req_sleep = 1'b0; req_power_down = 1'b0;
    wake_src = '0; wake_mask = '0; wake_timer_load = '0;
    pm_sleep_active = 1'b0; pm_power_down_active = 1'b0; err_clear = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_sleep_mode", -1, sleep_mode, 0);
    checkOutput("reset_power_down", -1, power_down, 0);
    checkOutput("reset_cpu_hold", -1, cpu_hold, 0);
    checkOutput("reset_wake_cause", -1, wake_cause, 0);
    checkOutput("reset_err", -1, err_timeout, 0);
    rst = 1'b0;

    $display("[TB] sleep round trip");
    applyStimulus(0, 1, 4, 4'b0010, 4'hF, 0, 1, -1, 1'b0, INF);
    $display("[TB] simultaneous requests, later requests ignored");
    applyStimulus(2, 2, 6, 4'b0100, 4'hF, 0, 2, -1, 1'b1, INF);
    $display("[TB] wake abort before ack");
    applyStimulus(0, 10, 3, 4'b1000, 4'b1000, 0, 1, -1, 1'b0, INF);
    $display("[TB] ack timeout then clear");
    applyStimulus(0, INF, INF, 4'b0001, 4'h0, 0, 1, 70, 1'b0, INF);
    applyStimulus(1, INF, INF, 4'b0001, 4'h0, 0, 1, 64, 1'b0, INF);
    $display("[TB] ack release timeout");
    applyStimulus(1, 3, 5, 4'b0010, 4'hF, 0, INF, -1, 1'b0, INF);
    $display("[TB] wake timer");
    applyStimulus(0, 2, TIMER_ON ? INF : 30, 4'b0001, 4'hF, 20, 1, -1, 1'b0, INF);
    applyStimulus(1, 1, 6, 4'b0101, 4'hF, 5, 1, -1, 1'b0, INF);

    $display("[TB] randomized transactions");
    for (int i = 0; i < 40; i++) begin
      kind   = $urandom_range(0, 2);
      da     = ($urandom_range(0, 7) == 0) ? INF : $urandom_range(1, 6);
      mask   = NW'($urandom);
      wbits  = NW'($urandom_range(1, 15));
      w      = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : $urandom_range(1, 80);
      n      = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 10);
      dr     = ($urandom_range(0, 9) == 0) ? INF : $urandom_range(1, 5);
      clrAt  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : -1;
      inject = 1'($urandom_range(0, 1));
      if (!TIMER_ON || n == 0) mask = mask | wbits;
      applyStimulus(kind, da, w, wbits, mask, n, dr, clrAt, inject, INF);
    end

    $display("[TB] masked power-down hold, then async reset");
    applyStimulus(0, INF, INF, 4'b0001, 4'h0, 0, 1, -1, 1'b0, INF);
    applyStimulus(1, 2, INF, 4'b0001, 4'h0, 0, 1, -1, 1'b0, 1000);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_power_down", -1, power_down, 0);
    checkOutput("async_sleep_mode", -1, sleep_mode, 0);
    checkOutput("async_cpu_hold", -1, cpu_hold, 0);
    checkOutput("async_busy", -1, busy, 0);
    checkOutput("async_err", -1, err_timeout, 0);
    checkOutput("async_wake_cause", -1, wake_cause, 0);
    @(negedge clk);
    rst = 1'b0;
    expCause = '0;
    expErr   = 1'b0;
    applyStimulus(0, 3, 7, 4'b1000, 4'hF, 0, 2, -1, 1'b0, INF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pm_sleep_wake_ctrl.md
Name: pm_sleep_wake_ctrl

Overview:
- Initiator side of the power-management handshake. Sits in the always-on domain and drives the sleep/power-down request levels into the power management unit.
- Waits for the power management unit's active acknowledgements.
- Monitors masked wake sources and an optional wake timer.
- Sequences exit: drop request, wait for ack release, settle. Then releases the CPU with a one-cycle wake pulse and a latched wake cause.

Parameters:
NUM_WAKE, 4, number of external wake sources
TIMER_W, 16, wake timer width
ACK_TIMEOUT, 64, max cycles waiting for ack assert/deassert before error
SETTLE_CYCLES, 8, cycles held in SETTLE after ack release before CPU resumes

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_sleep  in  1  software sleep request, single-cycle pulse
req_power_down  in  1  software power-down request, single-cycle pulse
wake_src  in  NUM_WAKE  level wake sources
wake_mask  in  NUM_WAKE  1 = source enabled
wake_timer_load  in  TIMER_W  auto-wake delay in cycles, 0 = timer off
pm_sleep_active  in  1  ack from power management unit
pm_power_down_active  in  1  ack from power management unit
err_clear  in  1  clears err_timeout
sleep_mode  out  1  sleep request level to power management unit
power_down  out  1  power-down request level to power management unit
cpu_hold  out  1  stall CPU, high whenever state != RUN
wake_pulse  out  1  one-cycle pulse on return to RUN
wake_cause  out  NUM_WAKE+1  latched cause; bit NUM_WAKE = timer
err_timeout  out  1  sticky ack-timeout flag
busy  out  1  state != RUN

Behaviour:
- Reset: state RUN. All outputs 0. Counters 0.
- All outputs are registered.
- States: RUN, SLP_REQ, SLEEP, PD_REQ, PDOWN, EXIT, SETTLE.
- RUN:
  - req_power_down → PD_REQ; power_down=1 next cycle.
  - Else req_sleep → SLP_REQ; sleep_mode=1 next cycle.
  - Both in the same cycle: power-down wins.
  - cpu_hold rises on the same edge as the request output.
- SLP_REQ / PD_REQ:
  - Matching ack high → SLEEP / PDOWN. Wake timer is loaded from wake_timer_load on this transition.
  - Masked wake (|(wake_src & wake_mask)) before ack → abort to EXIT. Request dropped; wake_cause captured.
  - Ack-wait counter reaches ACK_TIMEOUT → err_timeout=1 and go to EXIT.
- SLEEP / PDOWN:
  - Masked wake or timer expiry → EXIT.
  - On that edge: sleep_mode and power_down both driven 0, and wake_cause latched. wake_cause = {timer_hit, wake_src & wake_mask}; simultaneous causes are all recorded.
  - Requests arriving in any non-RUN state are ignored, not queued.
- EXIT:
  - Waits for pm_sleep_active=0 and pm_power_down_active=0, then → SETTLE.
  - Timeout after ACK_TIMEOUT cycles sets err_timeout and forces → SETTLE.
- SETTLE:
  - Counts SETTLE_CYCLES cycles, then → RUN.
  - wake_pulse=1 for exactly the first RUN cycle. cpu_hold=0 in the same cycle.
- Counter: one shared counter for ack wait and settle. Cleared on every state change, saturates at max.
- wake_cause:
  - Holds its value until the next entry to EXIT.
  - A timeout-abort with no wake active records 0.
- err_timeout:
  - Sticky; cleared only by err_clear or rst.
  - If err_clear and a new timeout coincide, set wins.
- Reset mid-operation: immediately returns to RUN with both request levels low.

Optional Feature:
WAKE_TIMER_EN
- Defined:
  - TIMER_W down-counter, loaded on entry to SLEEP/PDOWN.
  - With load N>0, EXIT is entered exactly N cycles after the SLEEP/PDOWN entry edge.
  - Load 0 never expires.
  - Timer frozen outside SLEEP/PDOWN.
- Undefined:
  - No timer logic; wake_timer_load ignored.
  - wake_cause[NUM_WAKE] tied 0.

Test Plan:
1. Sleep round trip: pulse req_sleep. Model ack 1 cycle after sleep_mode, release 1 cycle after drop. Then wake_src=4'b0010 with mask=4'b1111. → sleep_mode high until wake; wake_cause=5'b00010; wake_pulse exactly 8 cycles after ack release; cpu_hold low same cycle.
2. Priority and ignore: req_sleep and req_power_down in the same cycle. → power_down=1, sleep_mode=0. Then a req_sleep pulse in PDOWN → no effect.
3. Masking and abort: wake_mask=0, wake_src=4'hF in SLEEP → stays SLEEP. Separately, wake asserted in SLP_REQ before ack → EXIT, no SLEEP entry.
4. Ack timeout: ack never asserted after req_sleep. → err_timeout=1 after 64 cycles; returns to RUN with wake_cause=0; err_clear drops err_timeout.
5. Wake timer (WAKE_TIMER_EN): wake_timer_load=20, no wake_src. → EXIT 20 cycles after SLEEP entry; wake_cause=5'b10000. With load=0 → remains in SLEEP for 1000 cycles.
6. Async rst asserted in PDOWN. → power_down=0, cpu_hold=0, err_timeout=0 without a clock edge; normal sleep works after release.
